// File: rtl/bam_seq_mult.sv
// ============================================================================
// Module   : bam_seq_mult
// Purpose  : Sequential broken-array multiplier, one partial-product row per
//            clock, runtime exact / approximate (H_CUT, V_CUT) selection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bam_seq_mult #(
   parameter int N     = 8,
   parameter int H_CUT = 6,
   parameter int V_CUT = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           approx,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] prod
);

   localparam int c_IDX_W = (N > 2) ? $clog2(N) : 1;

   localparam logic [c_IDX_W-1:0] c_LAST_ROW  = c_IDX_W'(N - 1);
   localparam logic [c_IDX_W-1:0] c_FIRST_APX = c_IDX_W'(H_CUT);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_ACC  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [N-1:0]       r_a;
   logic [N-1:0]       r_b;
   logic               r_approx;
   logic [c_IDX_W-1:0] r_row;
   logic [2*N-1:0]     r_acc;

   logic               w_accept;
   logic               w_last;
   logic [N-1:0]       w_colmask;
   logic [N-1:0]       w_row_bits;
   logic [2*N-1:0]     w_row_term;

   assign w_accept = (r_state == c_IDLE) && in_valid;
   assign w_last   = (r_row == c_LAST_ROW);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_state_nxt = c_ACC;
         c_ACC:   if (w_last) w_state_nxt = c_DONE;
         c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         c_IDLE:  in_ready  = 1'b1;
         c_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Columns below V_CUT are dropped only in approximate mode.
   always_comb begin
      w_colmask = '0;
      for (int i = 0; i < N; i++) begin
         w_colmask[i] = !r_approx || ((i + int'(r_row)) >= V_CUT);
      end
   end

   assign w_row_bits = r_a & w_colmask & {N{r_b[r_row]}};
   assign w_row_term = {{N{1'b0}}, w_row_bits} << r_row;

   // ------------------------------------------------------------------------
   // Operand latches, row index and accumulator
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_approx <= 1'b0;
         r_row    <= '0;
         r_acc    <= '0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_approx <= approx;
         r_row    <= approx ? c_FIRST_APX : '0;
         r_acc    <= '0;
      end else if (r_state == c_ACC) begin
         r_acc <= r_acc + w_row_term;
         if (!w_last) begin
            r_row <= r_row + 1'b1;
         end
      end
   end

   assign prod = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_bam_seq_mult.sv
// ============================================================================
// Module   : tb_bam_seq_mult
// Purpose  : Directed and randomised self-checking bench for bam_seq_mult.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bam_seq_mult;

   localparam int c_N = 8;
   localparam int c_H = 6;
   localparam int c_V = 8;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [c_N-1:0]  a;
   logic [c_N-1:0]  b;
   logic            approx;
   logic            out_valid;
   logic            out_ready;
   logic [2*c_N-1:0] prod;

   int n_vec  = 0;
   int n_miss = 0;
   int n_in_hs  = 0;
   int n_out_hs = 0;
   int n_exp_in  = 0;
   int n_exp_out = 0;

   bam_seq_mult #(.N(c_N), .H_CUT(c_H), .V_CUT(c_V)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .approx    (approx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready)   n_in_hs++;
      if (rst_n && out_valid && out_ready) n_out_hs++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_bam(input logic [7:0] x, input logic [7:0] y,
                                           input logic ap);
      int s;
      s = 0;
      for (int j = 0; j < c_N; j++)
         for (int i = 0; i < c_N; i++)
            if (x[i] && y[j] && (!ap || (j >= c_H && i + j >= c_V)))
               s += (1 << (i + j));
      return s[15:0];
   endfunction

   // One full operation; returns at a negedge with the block back in IDLE.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tap,
                        input int stall, input logic [15:0] exp_p, input int exp_lat,
                        input string tag);
      int n;
      logic [15:0] held;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check({tag, "_rdy_timeout"}, 32'(in_ready), 32'd1);
         return;
      end
      a = ta; b = tb; approx = tap; in_valid = 1'b1;
      n_exp_in++;
      @(negedge clk);
      check({tag, "_accepted"}, 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         // Inputs and out_ready outside IDLE/DONE must be ignored.
         a = 8'($urandom); b = 8'($urandom); approx = 1'($urandom);
         in_valid = 1'($urandom); out_ready = 1'($urandom);
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'(exp_lat));
      if (!out_valid) return;
      check({tag, "_prod"}, 32'(prod), 32'(exp_p));
      held = prod;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check({tag, "_stall"}, {14'd0, out_valid, in_ready, prod}, {14'd0, 1'b1, 1'b0, held});
      end
      out_ready = 1'b1;
      n_exp_out++;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rap;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; approx = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_in_ready",  32'(in_ready),  32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_prod",      32'(prod),      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(8'd255, 8'd255, 1'b1, 0, 16'd48640, 2, "apx_ff");
      do_op(8'd15,  8'd192, 1'b1, 1, 16'd2560,  2, "apx_0f_c0");
      do_op(8'd255, 8'd255, 1'b0, 0, 16'd65025, 8, "ex_ff");
      do_op(8'd15,  8'd192, 1'b0, 2, 16'd2880,  8, "ex_0f_c0");
      do_op(8'd200, 8'd63,  1'b1, 0, 16'd0,     2, "apx_zero_rows");
      do_op(8'd0,   8'd255, 1'b0, 0, 16'd0,     8, "ex_zero_a");
      // Long back-pressure, then a new op issued on the first IDLE edge.
      do_op(8'd170, 8'd85,  1'b0, 10, 16'd14450, 8, "bp_stall");
      do_op(8'd128, 8'd128, 1'b1, 0, 16'd16384, 2, "bp_next");

      // Reset in the middle of an exact accumulation.
      a = 8'd255; b = 8'd255; approx = 1'b0; in_valid = 1'b1;
      n_exp_in++;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_prod",      32'(prod),      32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(8'd3, 8'd5, 1'b0, 0, 16'd15, 8, "post_rst");

      for (int t = 0; t < 1000; t++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rap = 1'($urandom);
         do_op(ra, rb, rap, int'($urandom_range(0, 3)), ref_bam(ra, rb, rap),
               rap ? 2 : 8, "rand");
      end

      @(negedge clk);
      check("hs_in_count",  32'(n_in_hs),  32'(n_exp_in));
      check("hs_out_count", 32'(n_out_hs), 32'(n_exp_out));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bam_seq_mult.md
# bam_seq_mult

Sequential, parametrised broken-array multiplier (BAM) for unsigned operands. It accumulates one partial-product row per clock and can drop rows below a horizontal cut and columns below a vertical cut. It extends the combinational fixed-width BAM generators with runtime exact/approximate mode selection and valid/ready handshakes on both sides. It is intended as an area-lean approximate multiplier in accelerator datapaths where a multi-cycle latency is acceptable.

## Interface
- `N`, 8: operand width in bits; N ≥ 2.
- `H_CUT`, 6: horizontal cut. Rows j < H_CUT (b[j]) are dropped in approximate mode; 0 ≤ H_CUT ≤ N-1.
- `V_CUT`, 8: vertical cut. Partial-product bits with column i+j < V_CUT are dropped in approximate mode; 0 ≤ V_CUT ≤ 2N-1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and mode are valid.
- `in_ready`  out  1  block can accept a new operation.
- `a`  in  N  multiplicand, unsigned.
- `b`  in  N  multiplier, unsigned.
- `approx`  in  1  1 = BAM with H_CUT/V_CUT; 0 = exact product.
- `out_valid`  out  1  `prod` holds a finished result.
- `out_ready`  in  1  consumer accepts `prod`.
- `prod`  out  2N  result.

## Operation
- Partial-product bit pp(i,j) = a[i] & b[j], weight 2^(i+j).
- Exact mode: prod = a*b.
- Approximate mode: prod = sum of pp(i,j) with j ≥ H_CUT and i+j ≥ V_CUT.
  - This is the full sum with no truncation: the top bit is kept. The maximum value fits in 2N bits, so there is no overflow.
- State machine: IDLE → ACC → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b, approx; clear the accumulator; set the row index to first = (approx ? H_CUT : 0); go to ACC.
- ACC, one row j per cycle:
  - acc += (a_l & colmask_j) << j.
  - colmask_j bit i = 1 if mode_l = exact or i+j ≥ V_CUT.
  - Row term = 0 when b_l[j] = 0, but the cycle is still spent.
  - Increment j. When j = N-1 has been added, go to DONE.
- Row count per operation:
  - R = N - H_CUT when approximate.
  - R = N when exact.
  - R is fixed and independent of the data.
- DONE:
  - out_valid = 1; prod = acc, held stable.
  - On out_ready go to IDLE.
  - in_ready = 0 in DONE and ACC, so there is no overlap between operations.
- Inputs a, b, approx and in_valid are ignored outside IDLE. Latched copies are used throughout an operation.
- `prod` is driven from the accumulator register at all times. It is meaningful only while out_valid = 1.

## Timing
- Reset (asynchronous, rst_n = 0): state IDLE, in_ready = 1, out_valid = 0, prod = 0, row index 0.
- Reset asserted mid-operation (ACC or DONE): the operation is abandoned immediately and all outputs take their reset values.
- Acceptance edge: cycle 0.
- out_valid rises R edges later:
  - approximate, defaults: 2 cycles;
  - exact, N = 8: 8 cycles.
- Result handshake completes on the edge where out_valid & out_ready are both 1. out_valid falls and in_ready rises after that edge.
- Minimum issue interval with out_ready held at 1: R+2 cycles.
- out_ready asserted during IDLE or ACC has no effect.
- out_ready held at 0 in DONE: the block stalls indefinitely with prod stable.
- in_valid held at 1 across the DONE→IDLE transition: a new operation is accepted on the first IDLE edge.
- Back-pressure causes no data loss: a result is only discarded by the DONE handshake or by reset.

## Test plan
- Defaults, approx = 1:
  - a = 255, b = 255 → prod = 48640, out_valid 2 cycles after acceptance.
  - a = 15, b = 192 → prod = 2560.
- Defaults, approx = 0:
  - a = 255, b = 255 → prod = 65025, latency 8 cycles.
  - a = 15, b = 192 → prod = 2880.
- approx = 1, a = 200, b = 63 (all kept rows zero) → prod = 0, latency still 2 cycles.
- Back-pressure: out_ready = 0 for 10 cycles in DONE → prod and out_valid stable and in_ready = 0 throughout. Then:
  - out_ready pulses → IDLE on the next edge;
  - a new in_valid is accepted on the following edge.
- rst_n pulsed low during ACC of an exact operation → out_valid = 0, prod = 0, in_ready = 1 at once. A subsequent operation with a = 3, b = 5, approx = 0 gives 15.
- Randomised sweep of 1000 operations with random mode and stalls:
  - each prod must equal the reference sum-of-kept-bits model;
  - every in/out handshake must pair one-to-one.
